// File: rtl/jeff_mem_arbiter.sv
// Single-port 256x8 RAM arbiter for the NanoJeff core (fetch / data read / data write) plus an
// external loader. Optional macro ARB_ROUND_ROBIN_EN switches RUN-state priority to rotating.
module jeff_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dr_req,
  input  logic [AW-1:0] dr_addr,
  output logic          dr_gnt,
  output logic          dr_rvalid,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  output logic          cpu_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a requester holds req/addr/data until it sees gnt in the same cycle;
  // a granted read returns on rdata with its *_rvalid exactly one cycle later.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ENTER = 2'd1,
    LOAD  = 2'd2,
    EXIT  = 2'd3
  } state_e;

  state_e state_q;
  logic   cpu_hold_q;
  logic   if_rv_q;
  logic   dr_rv_q;
  logic   ld_rv_q;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] P_WR = 2'd0;
  localparam logic [1:0] P_DR = 2'd1;
  localparam logic [1:0] P_IF = 2'd2;

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
`endif

  // Grants are combinational and forced off while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    dr_gnt = 1'b0;
    wr_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (!ld_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            case (ptr_q)
              P_WR: begin
                if (wr_req)      wr_gnt = 1'b1;
                else if (dr_req) dr_gnt = 1'b1;
                else if (if_req) if_gnt = 1'b1;
              end
              P_DR: begin
                if (dr_req)      dr_gnt = 1'b1;
                else if (if_req) if_gnt = 1'b1;
                else if (wr_req) wr_gnt = 1'b1;
              end
              default: begin
                if (if_req)      if_gnt = 1'b1;
                else if (wr_req) wr_gnt = 1'b1;
                else if (dr_req) dr_gnt = 1'b1;
              end
            endcase
`else
            if (wr_req)      wr_gnt = 1'b1;
            else if (dr_req) dr_gnt = 1'b1;
            else if (if_req) if_gnt = 1'b1;
`endif
          end
        end
        LOAD:    ld_gnt = ld_req;
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // The port just served drops to lowest priority; grants only occur in RUN.
  always_comb begin
    ptr_d = ptr_q;
    if (wr_gnt)      ptr_d = P_DR;
    else if (dr_gnt) ptr_d = P_IF;
    else if (if_gnt) ptr_d = P_WR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= P_WR;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      cpu_hold_q <= 1'b0;
      if_rv_q    <= 1'b0;
      dr_rv_q    <= 1'b0;
      ld_rv_q    <= 1'b0;
    end else begin
      if_rv_q <= if_gnt;
      dr_rv_q <= dr_gnt;
      ld_rv_q <= ld_gnt & ~ld_we;
      case (state_q)
        RUN: begin
          if (ld_req) begin
            state_q    <= ENTER;
            cpu_hold_q <= 1'b1;
          end
        end
        ENTER: begin
          state_q <= ld_req ? LOAD : EXIT;
        end
        LOAD: begin
          if (!ld_req) state_q <= EXIT;
        end
        default: begin
          state_q    <= RUN;
          cpu_hold_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = if_gnt | dr_gnt | wr_gnt | ld_gnt;
    mem_we    = wr_gnt | (ld_gnt & ld_we);
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (wr_gnt) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (dr_gnt) begin
      mem_addr = dr_addr;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ld_gnt) begin
      mem_addr = ld_addr;
      if (ld_we) mem_wdata = ld_wdata;
    end
  end

  assign if_rvalid   = if_rv_q;
  assign dr_rvalid   = dr_rv_q;
  assign ld_rvalid   = ld_rv_q;
  assign rdata       = mem_rdata;
  assign cpu_hold    = cpu_hold_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jeff_mem_arbiter.sv
// Directed bench for jeff_mem_arbiter: per-cycle grant/bus checks plus a read-response
// scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_jeff_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [1:0] S_RUN = 2'd0, S_ENTER = 2'd1, S_LOAD = 2'd2, S_EXIT = 2'd3;
  localparam logic [1:0] PT_IF = 2'd0, PT_DR = 2'd1, PT_LD = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dr_req, wr_req, ld_req, ld_we;
  logic [AW-1:0] if_addr, dr_addr, wr_addr, ld_addr;
  logic [DW-1:0] wr_data, ld_wdata;
  logic          if_gnt, dr_gnt, wr_gnt, ld_gnt;
  logic          if_rvalid, dr_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic          cpu_hold, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  jeff_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_rvalid(dr_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Synchronous single-port RAM model
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle check: grants {ld,wr,dr,if}, hold, mem bus and FSM state, sampled mid-cycle.
  task automatic cyc_chk(input string name, input logic [3:0] eg, input logic eh,
                         input logic [AW-1:0] ea, input logic ewe, input logic [DW-1:0] ewd,
                         input logic [1:0] es);
    @(negedge clk);
    check(name, {7'd0, dbg_state, ld_gnt, wr_gnt, dr_gnt, if_gnt, cpu_hold, mem_en, mem_we,
                 mem_addr, mem_wdata},
                {7'd0, es, eg, eh, (eg != 4'd0), ewe, ea, ewd});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [3:0] eg, input logic eh,
                     input logic [AW-1:0] ea, input logic ewe, input logic [DW-1:0] ewd,
                     input logic [1:0] es);
    cyc_chk(name, eg, eh, ea, ewe, ewd, es);
    adv();
  endtask

  task automatic push_rd(input logic [1:0] port, input logic [DW-1:0] data);
    exp_q.push_back({port, data});
  endtask

  // Monitor: every read-valid strobe pops one expected {port, data}.
  logic [2:0] mon_rv;
  logic [1:0] mon_port;
  logic [9:0] mon_exp;
  always @(negedge clk) begin
    mon_rv = {ld_rvalid, dr_rvalid, if_rvalid};
    if (mon_rv != 3'b000) begin
      case (mon_rv)
        3'b001:  mon_port = PT_IF;
        3'b010:  mon_port = PT_DR;
        3'b100:  mon_port = PT_LD;
        default: mon_port = 2'd3;
      endcase
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h expected none (t=%0t)",
                 mon_rv, rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rvalid_port_data", {22'd0, mon_port, rdata}, {22'd0, mon_exp});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'h50; ram[1] = 8'h55; ram[2] = 8'h5A; ram[3] = 8'h5F;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 8'h05;
    dr_req = 1'b0; dr_addr = 8'h00;
    wr_req = 1'b1; wr_addr = 8'h07; wr_data = 8'h33;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;

    // Outputs stay quiet under reset even with requests pending
    cyc("reset_outputs", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    reset = 1'b0; wr_req = 1'b0;

    // 1: reset right after a fetch grant kills its rvalid
    cyc_chk("t1_if_grant", 4'b0001, 1'b0, 8'h05, 1'b0, 8'h00, S_RUN);
    #1 reset = 1'b1;
    adv();
    cyc("t1_in_reset", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    reset = 1'b0; if_req = 1'b0;
    cyc("t1_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // 2: back-to-back fetches
    if_req = 1'b1;
    if_addr = 8'h00; push_rd(PT_IF, 8'h50); cyc("t2_if0", 4'b0001, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    if_addr = 8'h01; push_rd(PT_IF, 8'h55); cyc("t2_if1", 4'b0001, 1'b0, 8'h01, 1'b0, 8'h00, S_RUN);
    if_addr = 8'h02; push_rd(PT_IF, 8'h5A); cyc("t2_if2", 4'b0001, 1'b0, 8'h02, 1'b0, 8'h00, S_RUN);
    if_addr = 8'h03; push_rd(PT_IF, 8'h5F); cyc("t2_if3", 4'b0001, 1'b0, 8'h03, 1'b0, 8'h00, S_RUN);
    if_req = 1'b0;
    cyc("t2_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // 3: same-cycle write and read to one address; write goes first
    wr_req = 1'b1; wr_addr = 8'h0C; wr_data = 8'hAA;
    dr_req = 1'b1; dr_addr = 8'h0C;
    cyc("t3_wr", 4'b0100, 1'b0, 8'h0C, 1'b1, 8'hAA, S_RUN);
    wr_req = 1'b0;
    push_rd(PT_DR, 8'hAA);
    cyc("t3_dr", 4'b0010, 1'b0, 8'h0C, 1'b0, 8'h00, S_RUN);
    dr_req = 1'b0;
    cyc("t3_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // 4: loader takeover during a fetch stream
    if_req = 1'b1; if_addr = 8'h01;
    push_rd(PT_IF, 8'h55);
    cyc("t4_if", 4'b0001, 1'b0, 8'h01, 1'b0, 8'h00, S_RUN);
    if_addr = 8'h02; ld_req = 1'b1;
    cyc("t4_run_ld", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    cyc("t4_enter", 4'b0000, 1'b1, 8'h00, 1'b0, 8'h00, S_ENTER);
    ld_we = 1'b1; ld_addr = 8'h00; ld_wdata = 8'h51;
    cyc("t4_ld_wr", 4'b1000, 1'b1, 8'h00, 1'b1, 8'h51, S_LOAD);
    ld_we = 1'b0; ld_wdata = 8'h00;
    push_rd(PT_LD, 8'h51);
    cyc("t4_ld_rd", 4'b1000, 1'b1, 8'h00, 1'b0, 8'h00, S_LOAD);
    ld_req = 1'b0;
    cyc("t4_ld_drop", 4'b0000, 1'b1, 8'h00, 1'b0, 8'h00, S_LOAD);
    cyc("t4_exit", 4'b0000, 1'b1, 8'h00, 1'b0, 8'h00, S_EXIT);
    push_rd(PT_IF, 8'h5A);
    cyc("t4_resume", 4'b0001, 1'b0, 8'h02, 1'b0, 8'h00, S_RUN);
    if_req = 1'b0;
    cyc("t4_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // 5: all three CPU ports held for three cycles
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h11;
    dr_req = 1'b1; dr_addr = 8'h21;
    if_req = 1'b1; if_addr = 8'h22;
`ifdef ARB_ROUND_ROBIN_EN
    cyc("t5_c0", 4'b0100, 1'b0, 8'h20, 1'b1, 8'h11, S_RUN);
    push_rd(PT_DR, 8'h00);
    cyc("t5_c1", 4'b0010, 1'b0, 8'h21, 1'b0, 8'h00, S_RUN);
    push_rd(PT_IF, 8'h00);
    cyc("t5_c2", 4'b0001, 1'b0, 8'h22, 1'b0, 8'h00, S_RUN);
`else
    cyc("t5_c0", 4'b0100, 1'b0, 8'h20, 1'b1, 8'h11, S_RUN);
    cyc("t5_c1", 4'b0100, 1'b0, 8'h20, 1'b1, 8'h11, S_RUN);
    cyc("t5_c2", 4'b0100, 1'b0, 8'h20, 1'b1, 8'h11, S_RUN);
`endif
    wr_req = 1'b0; dr_req = 1'b0; if_req = 1'b0;
    cyc("t5_idle", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // 6: one-cycle loader pulse -> RUN, ENTER, EXIT, RUN with no loader grant
    if_req = 1'b1; if_addr = 8'h03; ld_req = 1'b1;
    cyc("t6_run", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    ld_req = 1'b0;
    cyc("t6_enter", 4'b0000, 1'b1, 8'h00, 1'b0, 8'h00, S_ENTER);
    cyc("t6_exit", 4'b0000, 1'b1, 8'h00, 1'b0, 8'h00, S_EXIT);
    push_rd(PT_IF, 8'h5F);
    cyc("t6_run_again", 4'b0001, 1'b0, 8'h03, 1'b0, 8'h00, S_RUN);
    if_req = 1'b0;
    cyc("t6_idle0", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);
    cyc("t6_idle1", 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, S_RUN);

    // Final report
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
